// File: rtl/weight_stream_source.sv
// Weight-stream transmitter: a DEPTH-word buffer written through a simple port and
// replayed num_reps times as AXI-Stream, with tlast marking the end of each pass.
module weight_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int REP_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [REP_WIDTH-1:0]  num_reps,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] weights_V_tdata,
    output logic                  weights_V_tvalid,
    input  logic                  weights_V_tready,
    output logic                  weights_V_tlast
);

    typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

    state_t state, state_nxt;

    logic [REP_WIDTH-1:0]  reps_q, rep;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_all;
    logic                  ran;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_vld_q, rd_last_q, rd_fin_q;

    logic [1:0][DATA_WIDTH-1:0] sk_data;
    logic [1:0]                 sk_last, sk_fin;
    logic                       sk_wp, sk_rp;
    logic [1:0]                 sk_cnt;

    logic       accept, push, pop, head_fin;
    logic       rd_en, rd_wrap, rd_final;
    logic [2:0] credit;

    assign accept   = (state == IDLE) && start;
    assign push     = rd_vld_q;
    assign pop      = weights_V_tvalid && weights_V_tready;
    assign head_fin = sk_fin[sk_rp];
    assign rd_wrap  = (rd_addr == ADDR_WIDTH'(DEPTH - 1));
    assign rd_final = rd_wrap && (rep == reps_q - REP_WIDTH'(1));

    // Skid occupancy one cycle from now plus the read in flight; a new read may only
    // be issued if it will still find a free slot even with no pop next cycle.
    assign credit = {1'b0, sk_cnt} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign rd_en  = (state == STREAM) && !rd_all && (credit <= 3'd1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_reps != '0) ? STREAM : FIN;
            STREAM:  if (pop && head_fin) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            reps_q  <= '0;
            rep     <= '0;
            rd_addr <= '0;
            rd_all  <= 1'b0;
            ran     <= 1'b0;
        end else if (accept) begin
            reps_q  <= num_reps;
            rep     <= '0;
            rd_addr <= '0;
            rd_all  <= 1'b0;
            ran     <= (num_reps != '0);
        end else begin
            if (rd_en) begin
                rd_addr <= rd_wrap ? '0 : rd_addr + ADDR_WIDTH'(1);
                if (rd_wrap)  rep    <= rep + REP_WIDTH'(1);
                if (rd_final) rd_all <= 1'b1;
            end
            if (state == FIN) ran <= 1'b0;
        end
    end

    // Buffer RAM: contents survive reset, writes only land while idle.
    always_ff @(posedge ap_clk) begin
        if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
        if (rd_en)                    rd_q <= mem[rd_addr];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_fin_q  <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_wrap;
            rd_fin_q  <= rd_final;
        end
    end

    // Two-entry output FIFO; entries are frozen until popped, which keeps AXI-S data stable.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sk_data <= '0;
            sk_last <= '0;
            sk_fin  <= '0;
            sk_wp   <= 1'b0;
            sk_rp   <= 1'b0;
            sk_cnt  <= '0;
        end else begin
            if (push) begin
                sk_data[sk_wp] <= rd_q;
                sk_last[sk_wp] <= rd_last_q;
                sk_fin[sk_wp]  <= rd_fin_q;
                sk_wp          <= ~sk_wp;
            end
            if (pop) sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign weights_V_tvalid = (sk_cnt != 2'd0);
    assign weights_V_tdata  = sk_data[sk_rp];
    assign weights_V_tlast  = weights_V_tvalid && sk_last[sk_rp];
    assign done             = (state == FIN);
    assign busy             = (state == STREAM) || ((state == FIN) && ran);

endmodule

// File: tb/tb_weight_stream_source.sv
// Scoreboard bench for weight_stream_source: expected beats are queued at start and
// popped by an independent monitor on every handshake.
module tb_weight_stream_source;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int RW    = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [RW-1:0] num_reps = '0;
    logic          busy, done, tvalid, tlast;
    logic [DW-1:0] tdata;
    logic          tready = 1'b1;

    weight_stream_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REP_WIDTH(RW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_reps(num_reps),
        .busy(busy), .done(done),
        .weights_V_tdata(tdata), .weights_V_tvalid(tvalid),
        .weights_V_tready(tready), .weights_V_tlast(tlast)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          f;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            checks = 0, failures = 0;
    int            done_cnt = 0, hs_cnt = 0, fin_st = 0;
    int            mode = 0, pi = 0, stall_n = 0;
    logic          pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, AXI-S hold rule, done/busy timing after the final beat.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        beat_t         e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                fin_st = 0;
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (fin_st == 1) begin
                    chk("fin_done", 32'(done), 32'd1);
                    chk("fin_tvalid", 32'(tvalid), 32'd0);
                    chk("fin_busy", 32'(busy), 32'd1);
                    fin_st = 2;
                end else if (fin_st == 2) begin
                    chk("idle_done", 32'(done), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                    fin_st = 0;
                end
                if (prev_stall) begin
                    chk("hold_tvalid", 32'(tvalid), 32'd1);
                    chk("hold_tdata", tdata, prev_d);
                    chk("hold_tlast", 32'(tlast), 32'(prev_l));
                end
                if (tvalid && tready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got %0h expected no beat", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_tdata", tdata, e.d);
                        chk("beat_tlast", 32'(tlast), 32'(e.l));
                        if (e.f) fin_st = 1;
                    end
                end
                prev_stall = tvalid && !tready;
                prev_d = tdata;
                prev_l = tlast;
            end
        end
    end

    // Sink: 0 always ready, 1 fixed pattern, 2 random, 3 stall 20 cycles from first tvalid.
    initial forever begin
        @(posedge ap_clk);
        #1;
        case (mode)
            0: tready = 1'b1;
            1: begin tready = pat[pi % 8]; pi++; end
            2: tready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_n < 20) begin
                    tready = 1'b0;
                    if (tvalid) stall_n++;
                end else tready = 1'b1;
            end
        endcase
    end

    task automatic wr(input int a, input logic [DW-1:0] v);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = v;
        @(posedge ap_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic start_run(input int reps);
        num_reps = RW'(reps);
        start = 1'b1;
        for (int r = 0; r < reps; r++)
            for (int a = 0; a < DEPTH; a++)
                exp_q.push_back('{d: model_mem[a], l: (a == DEPTH - 1),
                                  f: (r == reps - 1) && (a == DEPTH - 1)});
        @(posedge ap_clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run_end(input int base);
        int n = 0;
        while (done_cnt == base && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 2000) chk("done_timeout", 32'(n), 32'd0);
        repeat (3) @(negedge ap_clk);
        chk("done_pulses", 32'(done_cnt - base), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base, k, h0;
        logic bad_v, bad_b;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = DW'(32'h10 + i);
            wr(i, model_mem[i]);
        end

        // Full-rate run: latency and back-to-back beats across the pass boundary.
        base = done_cnt;
        start_run(2);
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("lat_tvalid_early", 32'(tvalid), 32'd0);
        @(negedge ap_clk);
        chk("lat_tvalid", 32'(tvalid), 32'd1);
        chk("lat_tdata", tdata, 32'h10);
        k = 0;
        while (!done && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        chk("no_bubble_cycles", 32'(k), 32'd8);
        run_end(base);

        // Fixed backpressure pattern.
        mode = 1;
        pi = 0;
        base = done_cnt;
        start_run(2);
        run_end(base);
        mode = 0;

        // Zero repetitions: done only.
        base = done_cnt;
        bad_v = 1'b0;
        bad_b = 1'b0;
        start_run(0);
        repeat (6) begin
            @(negedge ap_clk);
            if (tvalid) bad_v = 1'b1;
            if (busy) bad_b = 1'b1;
        end
        chk("zero_tvalid", 32'(bad_v), 32'd0);
        chk("zero_busy", 32'(bad_b), 32'd0);
        chk("zero_done_pulses", 32'(done_cnt - base), 32'd1);

        // Reset after three beats, then replay from word 0.
        h0 = hs_cnt;
        start_run(2);
        k = 0;
        while (hs_cnt < h0 + 3 && k < 100) begin
            @(negedge ap_clk);
            k++;
        end
        if (k >= 100) chk("mid_rst_timeout", 32'(k), 32'd0);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        base = done_cnt;
        start_run(1);
        run_end(base);

        // Write and start while busy are both ignored.
        base = done_cnt;
        start_run(1);
        chk("busy_high", 32'(busy), 32'd1);
        wr(1, 32'hFF);
        num_reps = RW'(5);
        start = 1'b1;
        @(posedge ap_clk);
        #1;
        start = 1'b0;
        run_end(base);
        base = done_cnt;
        start_run(1);
        run_end(base);

        // Long stall right at the first beat.
        mode = 3;
        stall_n = 0;
        base = done_cnt;
        start_run(1);
        k = 0;
        while (stall_n < 10 && k < 100) begin
            @(negedge ap_clk);
            k++;
        end
        @(negedge ap_clk);
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        chk("stall_tdata", tdata, 32'h10);
        run_end(base);

        // Random contents, lengths and backpressure; one run writes word 0 with start.
        mode = 2;
        for (int it = 0; it < 4; it++) begin
            for (int a = 1; a < DEPTH; a++) begin
                model_mem[a] = $urandom;
                wr(a, model_mem[a]);
            end
            model_mem[0] = $urandom;
            base = done_cnt;
            if (it == 1) begin
                wr_en = 1'b1;
                wr_addr = '0;
                wr_data = model_mem[0];
            end else begin
                wr(0, model_mem[0]);
            end
            start_run($urandom_range(1, 3));
            run_end(base);
        end
        mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
